// File: rtl/bcd_display_scanner_if.sv
// Signal bundle between the digit source (master) and the seven-segment scanner (slave).
// The slave drives the segment, decimal-point and anode pins plus the scan position.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 2
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_suppress;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        scan_idx;

  modport master (
    output enable, load, digits_in, dp_in, lz_suppress,
    input  seg_n, dp_n, an, scan_idx
  );

  modport slave (
    input  enable, load, digits_in, dp_in, lz_suppress,
    output seg_n, dp_n, an, scan_idx
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment driver: one shared decoder and segment bus, one digit per
// refresh slot, with a dark dead-time at the start of each slot to stop ghosting.
module bcd_display_scanner #(
  parameter int NUM_DIGITS    = 2,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_CYCLES  = 1000,
  parameter bit HEX_MODE      = 1'b0,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_scanner_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CNT_W-1:0]            pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]            scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0][3:0]  dig_q, dig_d;
  logic [NUM_DIGITS-1:0]       dp_q, dp_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [IDX_W-1:0]            idx_o_q, idx_o_d;
  logic [NUM_DIGITS-1:0]       lz_blank;
  logic                        zero_run;
  logic                        in_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0001100;
      4'd10:   s = HEX_MODE ? 7'b0001000 : SEG_OFF;
      4'd11:   s = HEX_MODE ? 7'b1100000 : SEG_OFF;
      4'd12:   s = HEX_MODE ? 7'b0110001 : SEG_OFF;
      4'd13:   s = HEX_MODE ? 7'b1000010 : SEG_OFF;
      4'd14:   s = HEX_MODE ? 7'b0110000 : SEG_OFF;
      default: s = HEX_MODE ? 7'b0111000 : SEG_OFF;
    endcase
    return s;
  endfunction

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (pre_cnt_q < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  // Prescaler and digit pointer only advance while scanning; disable freezes both.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    scan_idx_d = scan_idx_q;
    if (bus.enable) begin
      if (pre_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        pre_cnt_d  = '0;
        scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
      end else begin
        pre_cnt_d = pre_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    dig_d = dig_q;
    dp_d  = dp_q;
    if (bus.load) begin
      dig_d = bus.digits_in;
      dp_d  = bus.dp_in;
    end
  end

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (dig_q[i] == 4'd0);
      lz_blank[i] = zero_run;
    end
  end

  always_comb begin
    seg_d   = SEG_OFF;
    dpn_d   = 1'b1;
    an_d    = '0;
    idx_o_d = scan_idx_q;
    if (bus.enable && !in_blank) begin
      an_d[scan_idx_q] = 1'b1;
      dpn_d            = ~dp_q[scan_idx_q];
      if (!(bus.lz_suppress && lz_blank[scan_idx_q]))
        seg_d = seg_decode(dig_q[scan_idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      scan_idx_q <= '0;
      dig_q      <= '0;
      dp_q       <= '0;
      seg_q      <= SEG_OFF;
      dpn_q      <= 1'b1;
      an_q       <= '0;
      idx_o_q    <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      scan_idx_q <= scan_idx_d;
      dig_q      <= dig_d;
      dp_q       <= dp_d;
      seg_q      <= seg_d;
      dpn_q      <= dpn_d;
      an_q       <= an_d;
      idx_o_q    <= idx_o_d;
    end
  end

  assign bus.seg_n    = seg_q;
  assign bus.dp_n     = dpn_q;
  assign bus.an       = AN_ACTIVE_LOW ? ~an_q : an_q;
  assign bus.scan_idx = idx_o_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench: 2-digit decimal and hex instances share one stimulus bus; a 4-digit
// instance covers leading-zero suppression.
module tb_bcd_display_scanner;
  localparam logic [6:0] S_DARK = 7'b1111111;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0001100;
  localparam logic [6:0] SA = 7'b0001000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bcd_display_scanner_if #(.NUM_DIGITS(2)) if2 ();
  bcd_display_scanner_if #(.NUM_DIGITS(2)) ifh ();
  bcd_display_scanner_if #(.NUM_DIGITS(4)) if4 ();

  assign ifh.enable      = if2.enable;
  assign ifh.load        = if2.load;
  assign ifh.digits_in   = if2.digits_in;
  assign ifh.dp_in       = if2.dp_in;
  assign ifh.lz_suppress = if2.lz_suppress;

  bcd_display_scanner #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1'b0),
    .AN_ACTIVE_LOW(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  bcd_display_scanner #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1'b1),
    .AN_ACTIVE_LOW(1'b1)) uh (.clk(clk), .rst(rst), .bus(ifh));
  bcd_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1'b0),
    .AN_ACTIVE_LOW(1'b1)) u4 (.clk(clk), .rst(rst), .bus(if4));

  typedef struct {
    logic       ld;
    logic       en;
    logic [7:0] dig;
    logic [1:0] dp;
    logic [6:0] seg;
    logic       dpn;
    logic [1:0] an;
    logic       idx;
  } vec_t;

  vec_t tbl[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk2(input string nm, input logic [6:0] seg, input logic dpn,
                      input logic [1:0] an, input logic idx);
    chk({nm, ".seg"}, 16'(if2.seg_n), 16'(seg));
    chk({nm, ".dpn"}, 16'(if2.dp_n), 16'(dpn));
    chk({nm, ".an"},  16'(if2.an), 16'(an));
    chk({nm, ".idx"}, 16'(if2.scan_idx), 16'(idx));
  endtask

  task automatic chk4(input string nm, input logic [6:0] seg, input logic dpn,
                      input logic [3:0] an, input logic [1:0] idx);
    chk({nm, ".seg"}, 16'(if4.seg_n), 16'(seg));
    chk({nm, ".dpn"}, 16'(if4.dp_n), 16'(dpn));
    chk({nm, ".an"},  16'(if4.an), 16'(an));
    chk({nm, ".idx"}, 16'(if4.scan_idx), 16'(idx));
  endtask

  // Slot from the first lit cycle: three lit cycles, then the next slot's dark cycle.
  task automatic slot4(input string nm, input logic [3:0] an, input logic [6:0] seg,
                       input logic dpn, input logic [1:0] idx);
    tick();
    chk4({nm, ".lit"}, seg, dpn, an, idx);
    tick();
    tick();
    tick();
    chk4({nm, ".dead"}, S_DARK, 1'b1, 4'b1111, idx + 2'd1);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'h47, 2'b10, S_DARK, 1'b1, 2'b11, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h47, 2'b10, S7,     1'b1, 2'b10, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h47, 2'b10, S7,     1'b1, 2'b10, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h47, 2'b10, S7,     1'b1, 2'b10, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h47, 2'b10, S_DARK, 1'b1, 2'b11, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h47, 2'b10, S4,     1'b0, 2'b01, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h47, 2'b10, S4,     1'b0, 2'b01, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'h47, 2'b10, S4,     1'b0, 2'b01, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'h47, 2'b10, S_DARK, 1'b1, 2'b11, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h47, 2'b10, S7,     1'b1, 2'b10, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h47, 2'b10, S7,     1'b1, 2'b10, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h47, 2'b10, S7,     1'b1, 2'b10, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h47, 2'b10, S_DARK, 1'b1, 2'b11, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 8'h47, 2'b10, S4,     1'b0, 2'b01, 1'b1};
    // disable mid-slot 1 and load 99 while dark; count must resume where it froze
    tbl[14] = '{1'b1, 1'b0, 8'h99, 2'b00, S_DARK, 1'b1, 2'b11, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h99, 2'b00, S_DARK, 1'b1, 2'b11, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'h99, 2'b00, S_DARK, 1'b1, 2'b11, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 8'h99, 2'b00, S9,     1'b1, 2'b01, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 8'h99, 2'b00, S9,     1'b1, 2'b01, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 8'h99, 2'b00, S_DARK, 1'b1, 2'b11, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 8'h99, 2'b00, S9,     1'b1, 2'b10, 1'b0};

    if2.enable = 1'b0; if2.load = 1'b0; if2.digits_in = '0; if2.dp_in = '0;
    if2.lz_suppress = 1'b0;
    if4.enable = 1'b0; if4.load = 1'b0; if4.digits_in = '0; if4.dp_in = '0;
    if4.lz_suppress = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    chk2("reset", S_DARK, 1'b1, 2'b11, 1'b0);
    chk("reset.an4", 16'(if4.an), 16'hf);

    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if2.load      = tbl[i].ld;
      if2.enable    = tbl[i].en;
      if2.digits_in = tbl[i].dig;
      if2.dp_in     = tbl[i].dp;
      tick();
      chk2($sformatf("vec%0d", i), tbl[i].seg, tbl[i].dpn, tbl[i].an, tbl[i].idx);
    end

    // reset during slot 1 together with a load: load must be dropped
    if2.load = 1'b0; if2.enable = 1'b1;
    repeat (4) tick();
    chk2("pre_rst_slot1", S9, 1'b1, 2'b01, 1'b1);
    rst = 1'b1; if2.load = 1'b1; if2.digits_in = 8'h55; if2.dp_in = 2'b11;
    tick();
    chk2("rst_mid", S_DARK, 1'b1, 2'b11, 1'b0);
    rst = 1'b0; if2.load = 1'b0;
    tick();
    chk2("rst_dead", S_DARK, 1'b1, 2'b11, 1'b0);
    tick();
    chk2("rst_shadow0", S0, 1'b1, 2'b10, 1'b0);

    // codes above 9: blank in decimal mode, letters in hex mode
    if2.load = 1'b1; if2.digits_in = 8'hA5; if2.dp_in = 2'b00;
    tick();
    if2.load = 1'b0;
    tick();
    chk2("a5_d0", S5, 1'b1, 2'b10, 1'b0);
    chk("a5_hex_d0", 16'(ifh.seg_n), 16'(S5));
    tick();
    tick();
    chk2("a5_d1", S_DARK, 1'b1, 2'b01, 1'b1);
    chk("a5_hex_d1", 16'(ifh.seg_n), 16'(SA));
    chk("a5_hex_an", 16'(ifh.an), 16'(2'b01));

    // four digits, value 0030, dp on digit 2; load while disabled
    if4.load = 1'b1; if4.digits_in = 16'h0030; if4.dp_in = 4'b0100; if4.lz_suppress = 1'b1;
    tick();
    chk4("lz_load_dis", S_DARK, 1'b1, 4'b1111, 2'd0);
    if4.load = 1'b0; if4.enable = 1'b1;
    tick();
    chk4("lz_start", S_DARK, 1'b1, 4'b1111, 2'd0);
    slot4("lz1_d0", 4'b1110, S0,     1'b1, 2'd0);
    slot4("lz1_d1", 4'b1101, S3,     1'b1, 2'd1);
    slot4("lz1_d2", 4'b1011, S_DARK, 1'b0, 2'd2);
    slot4("lz1_d3", 4'b0111, S_DARK, 1'b1, 2'd3);
    if4.lz_suppress = 1'b0;
    slot4("lz0_d0", 4'b1110, S0, 1'b1, 2'd0);
    slot4("lz0_d1", 4'b1101, S3, 1'b1, 2'd1);
    slot4("lz0_d2", 4'b1011, S0, 1'b0, 2'd2);
    slot4("lz0_d3", 4'b0111, S0, 1'b1, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits. It replaces the per-digit combinational decoders with one shared decoder and one shared segment bus. The block latches a packed BCD/hex word and scans one digit per refresh slot. It adds leading-zero suppression, per-digit decimal points, an anti-ghosting dead-time and an optional hex mode. It sits between the BCD counter and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 2, number of digits scanned (1..8).
REFRESH_DIV, 100000, clk cycles per digit slot (>= 2).
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV).
HEX_MODE, 0, 1 = codes 10..15 show A b C d E F; 0 = codes 10..15 blank.
AN_ACTIVE_LOW, 1, 1 = anode outputs active-low.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = scan running; 0 = display dark, counters frozen
load  in  1  strobe: capture digits_in/dp_in into shadow registers
digits_in  in  4*NUM_DIGITS  packed codes, digit 0 (rightmost, LSD) in [3:0]
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
lz_suppress  in  1  1 = blank leading zeros
seg_n  out  7  active-low segments, seg_n[6]=a ... seg_n[0]=g
dp_n  out  1  active-low decimal point
an  out  NUM_DIGITS  anode enables, polarity per AN_ACTIVE_LOW
scan_idx  out  clog2(NUM_DIGITS) min 1  digit currently addressed

Behaviour:
- Reset (rst=1 at a clk edge):
  - pre_cnt=0, scan_idx=0, shadow digits=0, shadow dp=0.
  - seg_n=7'b1111111, dp_n=1, an=all inactive.
  - Reset takes priority over load and enable.
  - Reset mid-slot restarts the scan at digit 0.
- Shadow latch: load=1 at an edge captures digits_in and dp_in on that edge. Display logic reads only the shadow registers. load is honoured even when enable=0.
- Prescaler, when enable=1:
  - pre_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap, scan_idx increments, and wraps from NUM_DIGITS-1 to 0.
- enable=0: pre_cnt and scan_idx hold. Next-cycle outputs are seg_n=1111111, dp_n=1, an all inactive. Scanning resumes from the held position.
- Outputs are registered with 1-cycle latency: the outputs after edge t+1 reflect pre_cnt, scan_idx and the shadow values as they stood after edge t.
- Dead-time: while pre_cnt < BLANK_CYCLES, an is all inactive and seg_n=1111111.
- Otherwise exactly one an bit is active: an[scan_idx].
- Decode (active-low, order abcdefg):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
  - HEX_MODE=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - HEX_MODE=0: codes 10..15 give 1111111.
- Leading-zero suppression (lz_suppress=1): digit i (i >= 1) is blanked (seg_n=1111111) when digits NUM_DIGITS-1 down to i are all 0. Digit 0 is never blanked.
- dp_n = ~shadow_dp[scan_idx] whenever the anode is active, including on blanked digits. dp_n=1 during dead-time and when enable=0.
- NUM_DIGITS=1: scan_idx stays 0, and an[0] is active outside dead-time.

Test Plan:
- Reset: NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=1, rst high 3 cycles -> seg_n=1111111, dp_n=1, an=2'b11, scan_idx=0; after release, an=2'b10 from cycle 2 (pre_cnt=1 plus one cycle of latency).
- Scan/decode: load digits_in=8'h47, dp_in=2'b10, enable=1 -> slot 0: an=10, seg_n=0001111, dp_n=1; slot 1: an=01, seg_n=1001100, dp_n=0; each digit is lit for 3 of 4 cycles; scan_idx toggles every 4 cycles.
- Leading zeros: NUM_DIGITS=4, digits_in=16'h0030, lz_suppress=1 -> digits 3 and 2 blank, digit 1 = 0000110, digit 0 = 0000001; with lz_suppress=0, digits 3 and 2 = 0000001.
- Invalid codes: digits_in=8'hA5 -> HEX_MODE=0: digit 1 = 1111111, digit 0 = 0100100; HEX_MODE=1: digit 1 = 0001000.
- Enable/load interplay: deassert enable mid-slot 1 -> all dark next cycle, pre_cnt and scan_idx frozen; load 8'h99 while disabled; re-enable -> slot 1 resumes at the frozen count and shows 0001100.
- Reset mid-operation: assert rst during slot 1 with load=1 in the same cycle -> shadow digits=0, scan_idx=0, outputs dark; the load is ignored.
